// File: rtl/dram_responder_pkg.sv
// Shared constants and helpers for the DRAM responder and its storage array.
package dram_responder_pkg;

`include "config.svh"

   localparam int XLEN        = `XLEN;
   localparam int DRAM_STRB_W = `DRAM_STRB_W;
   // Wide enough for a LATENCY-2 preload with LATENCY up to 7.
   localparam int CNT_W       = 3;

   // Expand a per-byte strobe into a per-bit mask.
   function automatic logic [XLEN-1:0] strb_mask(input logic [DRAM_STRB_W-1:0] strb);
      logic [XLEN-1:0] mask;
      mask = '0;
      for (int b = 0; b < DRAM_STRB_W; b++) begin
         mask[8*b +: 8] = {8{strb[b]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/config.svh
// Global configuration for the DRAM responder slice: data path width and strobe width.
`ifndef DRAM_CONFIG_SVH
`define DRAM_CONFIG_SVH

`define XLEN 32
`define DRAM_STRB_W (`XLEN/8)

`endif

// File: rtl/dram_sram_array.sv
// Byte-writable synchronous single-port array. The read is registered and
// returns the word as it was before any write at the same edge.
module dram_sram_array
   import dram_responder_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [DRAM_STRB_W-1:0] wstrb,
   input  logic [AW-1:0]          addr,
   input  logic [XLEN-1:0]        wdata,
   output logic [XLEN-1:0]        rdata
);

   logic [XLEN-1:0] mem [DEPTH];
   logic [XLEN-1:0] mask;

   assign mask = strb_mask(wstrb);

   // Strobed byte write and registered read of the addressed word; contents are never reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= (mem[addr] & ~mask) | (wdata & mask);
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/dram_responder.sv
// Single-outstanding DRAM responder: accepts one load/store at a time, waits a
// configurable latency, then presents a response held until the requester takes it.
module dram_responder
   import dram_responder_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   rst_b,
   input  logic                   dram_req,
   input  logic                   dram_write,
   input  logic [XLEN-1:0]        dram_addr,
   input  logic [XLEN-1:0]        dram_wdata,
   input  logic [DRAM_STRB_W-1:0] dram_wstrb,
   output logic                   dram_addr_ok,
   input  logic                   dram_resp_ready,
   output logic                   dram_data_ok,
   output logic [XLEN-1:0]        dram_rdata
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [AW-1:0]    held_idx;
   logic             is_store;
   logic             accept;
   logic [AW-1:0]    req_idx;
   logic [AW-1:0]    sram_addr;
   logic [XLEN-1:0]  sram_rdata;
   logic             in_resp;
   logic             unused_addr;

   // Byte offset and bits above the array size do not select a word, so addresses wrap.
   assign req_idx     = dram_addr[AW+1:2];
   assign unused_addr = ^{dram_addr[XLEN-1:AW+2], dram_addr[1:0]};

   // Acceptance: free when idle, or when the current response is being consumed this cycle.
   always_comb begin
      accept = 1'b0;
      if (!rst_b && dram_req) begin
         if (state == IDLE) begin
            accept = 1'b1;
         end else if ((state == RESP) && dram_resp_ready) begin
            accept = 1'b1;
         end else begin
            accept = 1'b0;
         end
      end else begin
         accept = 1'b0;
      end
   end

   assign dram_addr_ok = accept;

   // Outside an acceptance the array keeps re-reading the accepted word; no write can
   // occur while a response is pending, so the read data stays stable through backpressure.
   assign sram_addr = accept ? req_idx : held_idx;

   dram_sram_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .we    (accept & dram_write),
      .wstrb (dram_wstrb),
      .addr  (sram_addr),
      .wdata (dram_wdata),
      .rdata (sram_rdata)
   );

   // Response outputs are decoded from registered state; stores answer with zero data.
   assign in_resp      = (state == RESP) & ~rst_b;
   assign dram_data_ok = in_resp;
   assign dram_rdata   = (in_resp & ~is_store) ? sram_rdata : '0;

   // Request FSM with latency counter; an acceptance always restarts the sequence.
   always_ff @(posedge clk) begin
      if (rst_b) begin
         state    <= IDLE;
         cnt      <= '0;
         held_idx <= '0;
         is_store <= 1'b0;
      end else if (accept) begin
         held_idx <= req_idx;
         is_store <= dram_write;
         if (LATENCY == 1) begin
            state <= RESP;
         end else begin
            state <= WAIT;
            cnt   <= CNT_LOAD;
         end
      end else begin
         case (state)
            IDLE: begin
               state <= IDLE;
            end
            WAIT: begin
               if (cnt == '0) begin
                  state <= RESP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: begin
               if (dram_resp_ready) begin
                  state <= IDLE;
               end else begin
                  state <= RESP;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dram_responder.sv
// Bench for dram_responder: two instances (LATENCY 1 and 4) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_dram_responder;
   import dram_responder_pkg::*;

   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   rst_b   [2];
   logic                   req     [2];
   logic                   wr      [2];
   logic                   ready   [2];
   logic                   addr_ok [2];
   logic                   data_ok [2];
   logic [XLEN-1:0]        addr    [2];
   logic [XLEN-1:0]        wdata   [2];
   logic [XLEN-1:0]        rdata   [2];
   logic [DRAM_STRB_W-1:0] wstrb   [2];

   int checks   = 0;
   int failures = 0;

   dram_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
      .clk(clk), .rst_b(rst_b[0]), .dram_req(req[0]), .dram_write(wr[0]),
      .dram_addr(addr[0]), .dram_wdata(wdata[0]), .dram_wstrb(wstrb[0]),
      .dram_addr_ok(addr_ok[0]), .dram_resp_ready(ready[0]),
      .dram_data_ok(data_ok[0]), .dram_rdata(rdata[0])
   );

   dram_responder #(.DEPTH(DEPTH), .LATENCY(4)) u_l4 (
      .clk(clk), .rst_b(rst_b[1]), .dram_req(req[1]), .dram_write(wr[1]),
      .dram_addr(addr[1]), .dram_wdata(wdata[1]), .dram_wstrb(wstrb[1]),
      .dram_addr_ok(addr_ok[1]), .dram_resp_ready(ready[1]),
      .dram_data_ok(data_ok[1]), .dram_rdata(rdata[1])
   );

   task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Move to just after the next rising edge, where inputs are driven.
   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   // Present a request and hold it until accepted (bounded); returns in the cycle after acceptance.
   task automatic issue(input int i, input logic w, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] d, input logic [DRAM_STRB_W-1:0] s);
      bit ok;
      int n;
      ok = 1'b0;
      n  = 0;
      req[i] = 1'b1; wr[i] = w; addr[i] = a; wdata[i] = d; wstrb[i] = s;
      while (!ok && n < 50) begin
         @(negedge clk);
         ok = addr_ok[i];
         next_cyc();
         n++;
      end
      req[i] = 1'b0;
      chk($sformatf("issue_accepted_%0d", i), {31'd0, ok}, 32'd1);
   endtask

   // Wait (bounded) for the response on instance i and compare its data.
   task automatic wait_resp(input int i, input string nm, input logic [XLEN-1:0] exp);
      bit seen;
      int n;
      seen = 1'b0;
      n    = 0;
      while (!seen && n < 20) begin
         @(negedge clk);
         seen = data_ok[i];
         if (seen) begin
            chk(nm, rdata[i], exp);
         end
         next_cyc();
         n++;
      end
      chk({nm, "_seen"}, {31'd0, seen}, 32'd1);
   endtask

   // Transaction-level model per instance: memory map, one pending response with
   // a countdown of cycles before it becomes visible.
   for (genvar g = 0; g < 2; g++) begin : g_model
      localparam int LAT = (g == 0) ? 1 : 4;
      logic [XLEN-1:0] mem_m [int];
      bit              started = 1'b0;
      bit              busy    = 1'b0;
      bit              known   = 1'b0;
      int              wait_c  = 0;
      logic [XLEN-1:0] resp    = '0;

      always @(negedge clk) begin
         bit              e_ok;
         bit              e_aok;
         int              idx;
         logic [XLEN-1:0] m;
         if (rst_b[g]) started = 1'b1;
         if (started) begin
            e_ok  = busy && (wait_c == 0) && !rst_b[g];
            e_aok = req[g] && !rst_b[g] && (!busy || (wait_c == 0 && ready[g]));
            chk($sformatf("model_data_ok_%0d", g), {31'd0, data_ok[g]}, {31'd0, e_ok});
            chk($sformatf("model_addr_ok_%0d", g), {31'd0, addr_ok[g]}, {31'd0, e_aok});
            if (e_ok && known) chk($sformatf("model_rdata_%0d", g), rdata[g], resp);
            if (rst_b[g]) begin
               busy = 1'b0;
            end else begin
               if (busy) begin
                  if (wait_c > 0) wait_c--;
                  else if (ready[g]) busy = 1'b0;
               end
               if (e_aok) begin
                  idx = int'((addr[g] >> 2) % DEPTH);
                  if (wr[g]) begin
                     if (mem_m.exists(idx) || wstrb[g] == '1) begin
                        m = mem_m.exists(idx) ? mem_m[idx] : '0;
                        for (int b = 0; b < DRAM_STRB_W; b++)
                           if (wstrb[g][b]) m[8*b +: 8] = wdata[g][8*b +: 8];
                        mem_m[idx] = m;
                     end
                     resp  = '0;
                     known = 1'b1;
                  end else begin
                     known = mem_m.exists(idx);
                     resp  = known ? mem_m[idx] : '0;
                  end
                  busy   = 1'b1;
                  wait_c = LAT - 1;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst_b[i] = 1'b1; req[i] = 1'b0; wr[i] = 1'b0; ready[i] = 1'b1;
         addr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
      end
      req[0] = 1'b1;
      repeat (2) next_cyc();
      // Reset state: no acceptance or response while reset is held.
      @(negedge clk);
      chk("rst_addr_ok", {31'd0, addr_ok[0]}, 32'd0);
      chk("rst_data_ok", {31'd0, data_ok[0]}, 32'd0);
      next_cyc();
      req[0] = 1'b0; rst_b[0] = 1'b0; rst_b[1] = 1'b0;
      next_cyc();

      // LATENCY=1: store then load, response one cycle after each acceptance.
      issue(0, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF);
      @(negedge clk);
      chk("l1_store_ack", {31'd0, data_ok[0]}, 32'd1);
      chk("l1_store_rdata_zero", rdata[0], 32'h0000_0000);
      next_cyc();
      issue(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
      @(negedge clk);
      chk("l1_load_ok", {31'd0, data_ok[0]}, 32'd1);
      chk("l1_load_0x10", rdata[0], 32'h1234_5678);
      next_cyc();

      // Byte strobes, back-to-back at one request per cycle.
      issue(0, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'hF);
      issue(0, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'b0101);
      issue(0, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
      @(negedge clk);
      chk("l1_strobe_merge", rdata[0], 32'hAA22_CC44);
      next_cyc();

      // Backpressure: response held for three cycles, then back-to-back accept.
      ready[0] = 1'b0;
      issue(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
      req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h0000_0020;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_data_ok_held", {31'd0, data_ok[0]}, 32'd1);
         chk("bp_rdata_held", rdata[0], 32'h1234_5678);
         chk("bp_no_accept", {31'd0, addr_ok[0]}, 32'd0);
         next_cyc();
      end
      ready[0] = 1'b1;
      @(negedge clk);
      chk("bp_b2b_accept", {31'd0, addr_ok[0]}, 32'd1);
      next_cyc();
      req[0] = 1'b0;
      @(negedge clk);
      chk("bp_next_rdata", rdata[0], 32'hAA22_CC44);
      next_cyc();

      // Address wrap: word 1024 aliases word 0.
      issue(0, 1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF);
      issue(0, 1'b0, 32'h0000_0000, 32'h0, 4'h0);
      @(negedge clk);
      chk("wrap_load_0", rdata[0], 32'hCAFE_F00D);
      next_cyc();

      // LATENCY=4 instance.
      issue(1, 1'b1, 32'h0000_0040, 32'h5A5A_A5A5, 4'hF);
      repeat (6) next_cyc();
      req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h0000_0040;
      @(negedge clk);
      chk("l4_accept_n", {31'd0, addr_ok[1]}, 32'd1);
      next_cyc();
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("l4_hold_addr_ok", {31'd0, addr_ok[1]}, 32'd0);
         chk("l4_hold_data_ok", {31'd0, data_ok[1]}, 32'd0);
         next_cyc();
      end
      @(negedge clk);
      chk("l4_first_data_ok", {31'd0, data_ok[1]}, 32'd1);
      chk("l4_rdata", rdata[1], 32'h5A5A_A5A5);
      chk("l4_b2b_accept", {31'd0, addr_ok[1]}, 32'd1);
      next_cyc();
      req[1] = 1'b0;

      // Reset while waiting: pending response is discarded, stored data survives.
      rst_b[1] = 1'b1;
      @(negedge clk);
      chk("l4_rst_data_ok", {31'd0, data_ok[1]}, 32'd0);
      next_cyc();
      rst_b[1] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("l4_no_resp_after_rst", {31'd0, data_ok[1]}, 32'd0);
         next_cyc();
      end
      issue(1, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
      wait_resp(1, "l4_store_persists", 32'h5A5A_A5A5);
      repeat (2) next_cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dram_responder.md
DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
REQ-001 The block SHALL use a single clock, clk; reset is rst_b, synchronous and active-high.
REQ-002 Parameter DEPTH, default 1024, SHALL set the number of XLEN-bit words; it must be a power of two.
REQ-003 Parameter LATENCY, default 1, range 1..7, SHALL set the cycles from request acceptance to the first data_ok.
REQ-004 Ports SHALL be:
- clk  in  1  clock
- rst_b  in  1  sync active-high reset
- dram_req  in  1  request valid
- dram_write  in  1  1=store, 0=load
- dram_addr  in  XLEN  byte address
- dram_wdata  in  XLEN  store data
- dram_wstrb  in  XLEN/8  byte write enables
- dram_addr_ok  out  1  request accepted this cycle
- dram_resp_ready  in  1  requester consumes response
- dram_data_ok  out  1  response valid
- dram_rdata  out  XLEN  load data, full word

Function
REQ-005 dram_addr_ok SHALL be combinational: dram_req & (state==IDLE | (state==RESP & dram_resp_ready)).
REQ-006 A request SHALL be accepted in a cycle with dram_req & dram_addr_ok; the word index is dram_addr[log2(DEPTH)+1:2]; dram_addr[1:0] and the upper bits are ignored, so addresses wrap modulo DEPTH words.
REQ-007 An accepted store SHALL write the bytes whose dram_wstrb bit is 1 at the acceptance clock edge; bytes with a 0 strobe bit are unchanged.
REQ-008 An accepted load SHALL read the array synchronously at the acceptance edge and hold the word internally until its response.
REQ-009 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-010 FSM transitions on acceptance:
- LATENCY==1 -> RESP.
- LATENCY>1 -> WAIT, with a counter loaded with LATENCY-2.
REQ-011 In WAIT, the counter SHALL decrement each cycle; at 0 the FSM moves to RESP.
REQ-012 In RESP, dram_data_ok=1 SHALL hold, with dram_rdata stable, until dram_resp_ready=1.
- Acceptance in the same cycle -> per REQ-010.
- No acceptance in the same cycle -> IDLE.
REQ-013 dram_data_ok SHALL be 0 in IDLE and WAIT.
REQ-014 Store responses SHALL also assert dram_data_ok; dram_rdata is then 0.
REQ-015 At most one request SHALL be outstanding; with LATENCY==1 the throughput is one request per cycle.
REQ-016 A store and a load to the same word in consecutive accepted requests SHALL return the new data, because the write commits before the next acceptance.
REQ-017 dram_req while in WAIT, or in RESP without dram_resp_ready, SHALL not be accepted (dram_addr_ok=0); the requester holds its request.

Reset
REQ-018 While rst_b=1:
- the FSM SHALL go to IDLE;
- the counter SHALL be cleared;
- dram_data_ok, dram_addr_ok and dram_rdata SHALL be 0;
- no writes SHALL occur.
REQ-019 Reset mid-operation SHALL discard the outstanding response; a store committed before reset persists.
REQ-020 Array contents SHALL not be reset.

Structure
REQ-021 XLEN SHALL come from config.svh; DRAM_STRB_W = XLEN/8 belongs in config.svh; the FSM state enum is local to the module.
REQ-022 The byte-writable synchronous array SHALL be the sub-module dram_sram_array (ports: clk, we, wstrb, addr, wdata, rdata); the FSM and counter stay in dram_responder.

Verification
REQ-023 Store then load, LATENCY=1: store 0x1234_5678 to 0x10, wstrb=0xF, resp_ready=1; then load 0x10 -> data_ok on the cycle after each acceptance; load rdata=0x1234_5678.
REQ-024 Byte strobes: word 0x20 preset to 0xAABB_CCDD; store wdata=0x1122_3344, wstrb=0b0101 -> load returns 0xAA22_CC44.
REQ-025 Latency, LATENCY=4: a load accepted at cycle N -> data_ok first high at N+4; addr_ok=0 for cycles N+1..N+3 while dram_req is held.
REQ-026 Backpressure: resp_ready=0 for 3 cycles during RESP -> data_ok and rdata held stable; the cycle resp_ready=1 with dram_req=1 -> addr_ok=1 (back-to-back accept).
REQ-027 Wrap and reset: DEPTH=1024, store to 0x1000 (word 1024) -> visible at load 0x0000; assert rst_b while in WAIT -> next cycle FSM=IDLE, data_ok=0, and no response is ever produced.
